// File: rtl/actuator_pkg.sv
// actuator_pkg -- shared definitions for the actuator pattern memory.
//   MEM_ADDR_W / MEM_DATA_W / MEM_DEPTH : array geometry (8-bit address, 16-bit words, 256 deep)
//   MEM_STORE_W : stored word width; one extra even-parity bit when ACTUATOR_MEM_PARITY_EN is defined
//   play_state_t : playback FSM states
//   even_parity  : parity bit that makes the stored word carry an even number of ones
package actuator_pkg;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 16;
  localparam int MEM_DEPTH  = 256;

`ifdef ACTUATOR_MEM_PARITY_EN
  localparam int MEM_STORE_W = MEM_DATA_W + 1;
`else
  localparam int MEM_STORE_W = MEM_DATA_W;
`endif

  typedef enum logic [1:0] {
    PLAY_IDLE    = 2'd0,
    PLAY_FETCH   = 2'd1,
    PLAY_PRESENT = 2'd2,
    PLAY_DONE    = 2'd3
  } play_state_t;

  function automatic logic even_parity(input logic [MEM_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/actuator_mem_array.sv
// actuator_mem_array -- 256-word single-port storage, no reset.
//   clock : write clock
//   we    : write enable for this edge
//   addr  : shared read/write address
//   wdata : stored word (data plus optional parity bit)
//   rdata : combinational read of the word at addr; the caller registers it
module actuator_mem_array
  import actuator_pkg::*;
(
  input  logic                   clock,
  input  logic                   we,
  input  logic [MEM_ADDR_W-1:0]  addr,
  input  logic [MEM_STORE_W-1:0] wdata,
  output logic [MEM_STORE_W-1:0] rdata
);

  logic [MEM_STORE_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/actuator_memory.sv
// actuator_memory -- host-accessible pattern memory with a valid/ready playback engine.
// Optional build macro: ACTUATOR_MEM_PARITY_EN (per-word even parity, sticky parity_error).
// Ports:
//   clock, reset_n                         : clock, asynchronous active-low reset
//   memory_enable_n/write_n/read_n         : host strobe and qualifiers (active low)
//   memory_address, memory_data_out        : host address and write data
//   memory_data_in                         : registered host read data, held between reads
//   play_start, play_base, play_length     : playback launch (base/length sampled on start)
//   play_word, play_valid, play_ready      : playback stream
//   play_busy, play_done                   : playback status, end-of-playback pulse
//   parity_error                           : sticky parity fault (0 unless parity build)
module actuator_memory
  import actuator_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  memory_enable_n,
  input  logic                  memory_write_n,
  input  logic                  memory_read_n,
  input  logic [MEM_ADDR_W-1:0] memory_address,
  input  logic [MEM_DATA_W-1:0] memory_data_out,
  output logic [MEM_DATA_W-1:0] memory_data_in,
  input  logic                  play_start,
  input  logic [MEM_ADDR_W-1:0] play_base,
  input  logic [MEM_ADDR_W-1:0] play_length,
  output logic [MEM_DATA_W-1:0] play_word,
  output logic                  play_valid,
  input  logic                  play_ready,
  output logic                  play_busy,
  output logic                  play_done,
  output logic                  parity_error
);

  play_state_t            state, state_nxt;
  logic [MEM_ADDR_W-1:0]  play_addr;
  logic [MEM_ADDR_W-1:0]  play_count;
  logic                   host_access, host_wr, host_rd, fetch_go, handshake;
  logic [MEM_ADDR_W-1:0]  arr_addr;
  logic [MEM_STORE_W-1:0] arr_wdata, arr_rdata;
  logic [MEM_DATA_W-1:0]  rd_word;

  // Host wins the single port; a write with both qualifiers low is a write only.
  assign host_access = !memory_enable_n && (!memory_write_n || !memory_read_n);
  assign host_wr     = !memory_enable_n && !memory_write_n;
  assign host_rd     = !memory_enable_n &&  memory_write_n && !memory_read_n;
  assign fetch_go    = (state == PLAY_FETCH) && !host_access;
  assign handshake   = (state == PLAY_PRESENT) && play_ready;
  assign arr_addr    = host_access ? memory_address : play_addr;
  assign rd_word     = arr_rdata[MEM_DATA_W-1:0];

`ifdef ACTUATOR_MEM_PARITY_EN
  assign arr_wdata = {even_parity(memory_data_out), memory_data_out};
`else
  assign arr_wdata = memory_data_out;
`endif

  actuator_mem_array u_array (
    .clock (clock),
    .we    (host_wr),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_nxt  = state;
    play_valid = 1'b0;
    play_busy  = 1'b1;
    unique case (state)
      PLAY_IDLE: begin
        play_busy = 1'b0;
        if (play_start) begin
          state_nxt = (play_length == '0) ? PLAY_DONE : PLAY_FETCH;
        end
      end
      PLAY_FETCH: begin
        if (fetch_go) state_nxt = PLAY_PRESENT;
      end
      PLAY_PRESENT: begin
        play_valid = 1'b1;
        // play_count still holds the pre-decrement value here
        if (play_ready) state_nxt = (play_count == 8'd1) ? PLAY_DONE : PLAY_FETCH;
      end
      PLAY_DONE: begin
        state_nxt = PLAY_IDLE;
      end
      default: state_nxt = PLAY_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= PLAY_IDLE;
      play_addr      <= '0;
      play_count     <= '0;
      memory_data_in <= '0;
      play_word      <= '0;
      play_done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      // done is registered off the DONE state, so it lands on the IDLE return cycle
      play_done <= (state == PLAY_DONE);
      if (host_rd) memory_data_in <= rd_word;
      // play_word is a private copy, so host writes cannot disturb a presented word
      if (fetch_go) play_word <= rd_word;
      if ((state == PLAY_IDLE) && play_start) begin
        play_addr  <= play_base;
        play_count <= play_length;
      end else if (handshake) begin
        play_addr  <= play_addr + 8'd1;
        play_count <= play_count - 8'd1;
      end
    end
  end

`ifdef ACTUATOR_MEM_PARITY_EN
  logic rd_bad;
  assign rd_bad = ^arr_rdata;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      parity_error <= 1'b0;
    end else if ((host_rd || fetch_go) && rd_bad) begin
      parity_error <= 1'b1;
    end
  end
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_actuator_memory.sv
// tb_actuator_memory -- directed bench for actuator_memory: host read/write,
// playback with wrap, backpressure, host contention, zero length, reset abort,
// and (parity build) a stored bit flip.
module tb_actuator_memory;
  import actuator_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        memory_enable_n, memory_write_n, memory_read_n;
  logic [7:0]  memory_address;
  logic [15:0] memory_data_out, memory_data_in;
  logic        play_start, play_ready, play_valid, play_busy, play_done, parity_error;
  logic [7:0]  play_base, play_length;
  logic [15:0] play_word;

  int errors = 0;
  int checks = 0;
  logic [15:0] model [256];
  logic [15:0] got [$];
  logic [15:0] exp_q [$];
  int done_cnt;

  actuator_memory dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .memory_enable_n (memory_enable_n),
    .memory_write_n  (memory_write_n),
    .memory_read_n   (memory_read_n),
    .memory_address  (memory_address),
    .memory_data_out (memory_data_out),
    .memory_data_in  (memory_data_in),
    .play_start      (play_start),
    .play_base       (play_base),
    .play_length     (play_length),
    .play_word       (play_word),
    .play_valid      (play_valid),
    .play_ready      (play_ready),
    .play_busy       (play_busy),
    .play_done       (play_done),
    .parity_error    (parity_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic host_write(input logic [7:0] a, input logic [15:0] d, input bit both_low);
    memory_enable_n = 1'b0;
    memory_write_n  = 1'b0;
    memory_read_n   = both_low ? 1'b0 : 1'b1;
    memory_address  = a;
    memory_data_out = d;
    model[a] = d;
    tick();
    memory_enable_n = 1'b1;
    memory_write_n  = 1'b1;
    memory_read_n   = 1'b1;
  endtask

  task automatic host_read(input logic [7:0] a);
    memory_enable_n = 1'b0;
    memory_read_n   = 1'b0;
    memory_address  = a;
    tick();
    memory_enable_n = 1'b1;
    memory_read_n   = 1'b1;
  endtask

  task automatic start_play(input logic [7:0] b, input logic [7:0] len);
    play_start  = 1'b1;
    play_base   = b;
    play_length = len;
    tick();
    play_start  = 1'b0;
  endtask

  // Collects handshaken words until play_done. With hrd set, the host reads
  // continuously for the first cycles and then two of every three cycles.
  task automatic collect(input int max_cyc, input bit hrd);
    bit fin = 0;
    bit pend = 0;
    logic [7:0] pa = 8'h00;
    got.delete();
    done_cnt = 0;
    for (int c = 0; c < max_cyc && !fin; c++) begin
      if (pend) chk("host_rd_during_play", {16'h0, memory_data_in}, {16'h0, model[pa]});
      pend = 0;
      if (hrd && c <= 6) chk("play_stalled_by_host", {31'h0, play_valid}, 32'h0);
      if (play_valid && play_ready) got.push_back(play_word);
      if (play_done) begin
        done_cnt++;
        fin = 1;
      end
      if (hrd && !fin && (c < 6 || (c % 3) != 2)) begin
        pa = 8'h10 + 8'(c % 3);
        memory_enable_n = 1'b0;
        memory_read_n   = 1'b0;
        memory_address  = pa;
        pend = 1;
      end else begin
        memory_enable_n = 1'b1;
        memory_read_n   = 1'b1;
      end
      if (!fin) tick();
    end
    memory_enable_n = 1'b1;
    memory_read_n   = 1'b1;
    if (!fin) chk("play_timeout", 32'h0, 32'h1);
  endtask

  task automatic check_seq(input string tag);
    chk({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk(tag, (i < got.size()) ? {16'h0, got[i]} : 32'hDEAD_0000, {16'h0, exp_q[i]});
  endtask

  task automatic wait_valid(input int max_cyc);
    int n = 0;
    while (!play_valid && n < max_cyc) begin
      tick();
      n++;
    end
    if (!play_valid) chk("wait_valid_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    reset_n = 1'b0;
    memory_enable_n = 1'b1; memory_write_n = 1'b1; memory_read_n = 1'b1;
    memory_address = '0; memory_data_out = '0;
    play_start = 1'b0; play_base = '0; play_length = '0; play_ready = 1'b0;

    // reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_data_in", {16'h0, memory_data_in}, 32'h0);
    chk("rst_play_word", {16'h0, play_word}, 32'h0);
    chk("rst_flags", {28'h0, play_valid, play_busy, play_done, parity_error}, 32'h0);
    reset_n = 1'b1;
    tick();

    // host write / read / hold
    host_write(8'h10, 16'hA5A5, 0);
    host_read(8'h10);
    chk("host_rd_a5a5", {16'h0, memory_data_in}, 32'h0000_A5A5);
    host_write(8'h11, 16'h1234, 0);
    tick();
    chk("host_rd_held", {16'h0, memory_data_in}, 32'h0000_A5A5);
    host_write(8'h12, 16'h5555, 1);
    chk("both_low_no_read", {16'h0, memory_data_in}, 32'h0000_A5A5);
    host_read(8'h12);
    chk("both_low_wrote", {16'h0, memory_data_in}, 32'h0000_5555);

    // playback across the 0xFF -> 0x00 wrap
    host_write(8'hFE, 16'h1111, 0);
    host_write(8'hFF, 16'h2222, 0);
    host_write(8'h00, 16'h3333, 0);
    play_ready = 1'b1;
    start_play(8'hFE, 8'd3);
    chk("busy_after_start", {31'h0, play_busy}, 32'h1);
    collect(40, 0);
    exp_q = '{16'h1111, 16'h2222, 16'h3333};
    check_seq("wrap_words");
    chk("wrap_done_pulses", done_cnt, 1);
    tick();
    chk("wrap_done_one_cycle", {30'h0, play_done, play_busy}, 32'h0);

    // backpressure, ignored restart, host write to the presented address
    host_write(8'h30, 16'hBEEF, 0);
    host_write(8'h31, 16'hCAFE, 0);
    play_ready = 1'b0;
    start_play(8'h30, 8'd2);
    wait_valid(10);
    chk("stall_first_word", {16'h0, play_word}, 32'h0000_BEEF);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_hold", {15'h0, play_valid, play_word}, 32'h0001_BEEF);
    end
    start_play(8'h31, 8'd5);
    host_write(8'h30, 16'h0BAD, 0);
    chk("presented_unchanged", {15'h0, play_valid, play_word}, 32'h0001_BEEF);
    play_ready = 1'b1;
    collect(40, 0);
    exp_q = '{16'hBEEF, 16'hCAFE};
    check_seq("stall_words");
    tick();
    start_play(8'h30, 8'd1);
    collect(20, 0);
    exp_q = '{16'h0BAD};
    check_seq("later_fetch");
    tick();

    // host reads contend with playback
    host_write(8'h40, 16'h0A01, 0);
    host_write(8'h41, 16'h0A02, 0);
    host_write(8'h42, 16'h0A03, 0);
    host_write(8'h43, 16'h0A04, 0);
    start_play(8'h40, 8'd4);
    collect(100, 1);
    exp_q = '{16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04};
    check_seq("contend_words");
    chk("contend_done", done_cnt, 1);
    tick();

    // zero length: done two cycles after start, never valid
    play_start = 1'b1; play_base = 8'h55; play_length = 8'd0;
    tick();
    play_start = 1'b0;
    chk("len0_c1", {29'h0, play_valid, play_busy, play_done}, 32'b010);
    tick();
    chk("len0_c2", {29'h0, play_valid, play_busy, play_done}, 32'b001);
    tick();
    chk("len0_c3", {29'h0, play_valid, play_busy, play_done}, 32'b000);

    // reset mid-playback
    play_ready = 1'b0;
    start_play(8'hFE, 8'd3);
    wait_valid(10);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_outputs", {16'h0, play_word}, 32'h0);
    chk("abort_data_in", {16'h0, memory_data_in}, 32'h0);
    chk("abort_flags", {28'h0, play_valid, play_busy, play_done, parity_error}, 32'h0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", {30'h0, play_done, play_busy}, 32'h0);
    end
    host_read(8'h10);
    chk("array_kept_reset", {16'h0, memory_data_in}, 32'h0000_A5A5);

`ifdef ACTUATOR_MEM_PARITY_EN
    host_write(8'h20, 16'h0001, 0);
    host_read(8'h20);
    chk("parity_clean", {31'h0, parity_error}, 32'h0);
    dut.u_array.mem[8'h20][0] = ~dut.u_array.mem[8'h20][0];
    host_read(8'h20);
    chk("parity_set", {31'h0, parity_error}, 32'h1);
    host_read(8'h10);
    tick();
    chk("parity_sticky", {31'h0, parity_error}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("parity_cleared", {31'h0, parity_error}, 32'h0);
    tick();
    reset_n = 1'b1;
`else
    host_read(8'h12);
    chk("parity_tied_low", {31'h0, parity_error}, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
